// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - CPU instruction/data memory responder with byte-serial boot loader
// Optional cycle counter at CYC_ADDR is enabled by defining CPU_MEM_CYCCNT_EN.
module cpu_mem_responder #(
    parameter int          IAW      = 8,
    parameter int          DAW      = 8,
    parameter logic [15:0] GPO_ADDR = 16'hFFFF,
    parameter logic [15:0] CYC_ADDR = 16'hFFFE
) (
    input  logic        CK,
    input  logic        RST_N,
    input  logic [15:0] IA,
    output logic [15:0] ID,
    input  logic [15:0] DA,
    inout  wire  [15:0] DD,
    input  logic        RW,
    output logic        CPU_RST,
    input  logic        LD_VALID,
    output logic        LD_READY,
    input  logic [7:0]  LD_DATA,
    input  logic        LD_LAST,
    input  logic        LD_START,
    output logic [15:0] GPO
);
    typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [IAW-1:0] PTR_ONE = {{(IAW-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [IAW-1:0] ptr_q, ptr_d;
    logic           phase_lo_q, phase_lo_d;
    logic [7:0]     hi_q, hi_d;
    logic [15:0]    gpo_q, gpo_d;
    logic [15:0]    rd_data;

    logic [15:0] imem [2**IAW];
    logic [15:0] dmem [2**DAW];

    logic accept, imem_we, dmem_we, cpu_wr, da_is_gpo, da_in_range;

    // LD_START wins over a coincident byte, so that byte is never accepted.
    assign accept      = LD_VALID && (state_q == ST_LOAD) && !LD_START;
    assign imem_we     = accept && phase_lo_q;
    assign cpu_wr      = !RW && (state_q == ST_RUN);
    assign da_is_gpo   = (DA == GPO_ADDR);
    assign da_in_range = ((DA >> DAW) == 16'd0);
    assign dmem_we     = cpu_wr && da_in_range && !da_is_gpo;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        phase_lo_d = phase_lo_q;
        hi_d       = hi_q;
        gpo_d      = gpo_q;
        CPU_RST    = (state_q == ST_LOAD);
        LD_READY   = (state_q == ST_LOAD);
        if (cpu_wr && da_is_gpo) begin
            gpo_d = DD;
        end
        if (LD_START) begin
            state_d    = ST_LOAD;
            ptr_d      = '0;
            phase_lo_d = 1'b0;
        end else if (accept) begin
            if (!phase_lo_q) begin
                hi_d       = LD_DATA;
                phase_lo_d = 1'b1;
            end else begin
                ptr_d      = ptr_q + PTR_ONE;
                phase_lo_d = 1'b0;
                if (LD_LAST) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_LOAD;
            ptr_q      <= '0;
            phase_lo_q <= 1'b0;
            hi_q       <= '0;
            gpo_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            phase_lo_q <= phase_lo_d;
            hi_q       <= hi_d;
            gpo_q      <= gpo_d;
        end
    end

    always_ff @(posedge CK) begin
        if (imem_we) begin
            imem[ptr_q] <= {hi_q, LD_DATA};
        end
        if (dmem_we) begin
            dmem[DA[DAW-1:0]] <= DD;
        end
    end

`ifdef CPU_MEM_CYCCNT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q + 16'd1;
        if ((state_q == ST_LOAD) || (cpu_wr && (DA == CYC_ADDR))) begin
            cyc_d = '0;
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`else
    logic unused_cyc_addr;
    assign unused_cyc_addr = ^CYC_ADDR;
`endif

    always_comb begin
        rd_data = '0;
        if (da_is_gpo) begin
            rd_data = gpo_q;
`ifdef CPU_MEM_CYCCNT_EN
        end else if (DA == CYC_ADDR) begin
            rd_data = cyc_q;
`endif
        end else if (da_in_range) begin
            rd_data = dmem[DA[DAW-1:0]];
        end
    end

    assign ID  = ((IA >> IAW) == 16'd0) ? imem[IA[IAW-1:0]] : 16'd0;
    assign DD  = RW ? rd_data : 16'bz;
    assign GPO = gpo_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;
    logic        ck = 1'b0;
    logic        rst_n, rw, ld_valid, ld_last, ld_start;
    logic [15:0] ia, da, dd_drv, id, gpo;
    logic [7:0]  ld_data;
    logic        cpu_rst, ld_ready;
    wire  [15:0] dd;

    assign dd = rw ? 16'bz : dd_drv;
    always #5 ck = ~ck;

    cpu_mem_responder dut (
        .CK(ck), .RST_N(rst_n), .IA(ia), .ID(id), .DA(da), .DD(dd), .RW(rw),
        .CPU_RST(cpu_rst), .LD_VALID(ld_valid), .LD_READY(ld_ready),
        .LD_DATA(ld_data), .LD_LAST(ld_last), .LD_START(ld_start), .GPO(gpo)
    );

    int n_vec = 0;
    int n_miss = 0;

    // Reference model: load progress is a plain count of accepted bytes.
    bit          m_run;
    int          m_nb;
    logic [7:0]  m_hi;
    logic [15:0] m_gpo, m_cyc;
    logic [15:0] m_imem [256];
    bit          m_ik   [256];
    logic [15:0] m_dmem [256];
    bit          m_dk   [256];

    typedef struct {
        logic [15:0] da;
        logic [15:0] wd;
        logic [15:0] rd;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        m_run = 0; m_nb = 0; m_hi = '0; m_gpo = '0; m_cyc = '0;
    endtask

    task automatic mdl_edge();
        if (m_run && !rw) begin
            if (da == 16'hFFFF) m_gpo = dd_drv;
            else if (da < 16'd256) begin m_dmem[da[7:0]] = dd_drv; m_dk[da[7:0]] = 1; end
        end
        if (!m_run || (!rw && da == 16'hFFFE)) m_cyc = '0;
        else m_cyc = m_cyc + 16'd1;
        if (ld_start) begin
            m_run = 0; m_nb = 0;
        end else if (!m_run && ld_valid) begin
            if (m_nb % 2 == 0) m_hi = ld_data;
            else begin
                m_imem[(m_nb / 2) % 256] = {m_hi, ld_data};
                m_ik[(m_nb / 2) % 256] = 1;
                if (ld_last) m_run = 1;
            end
            m_nb++;
        end
    endtask

    task automatic tick();
        mdl_edge();
        @(posedge ck);
        #1;
    endtask

    task automatic mdl_rd(input logic [15:0] a, output logic [15:0] e, output bit k);
        k = 1; e = '0;
        if (a == 16'hFFFF) e = m_gpo;
`ifdef CPU_MEM_CYCCNT_EN
        else if (a == 16'hFFFE) e = m_cyc;
`endif
        else if (a < 16'd256) begin k = m_dk[a[7:0]]; e = m_dmem[a[7:0]]; end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e;
        bit k;
        check({tag, ".cpu_rst"}, {15'd0, cpu_rst}, {15'd0, !m_run});
        check({tag, ".ld_ready"}, {15'd0, ld_ready}, {15'd0, !m_run});
        check({tag, ".gpo"}, gpo, m_gpo);
        if (ia >= 16'd256) check({tag, ".id_oor"}, id, 16'd0);
        else if (m_ik[ia[7:0]]) check({tag, ".id"}, id, m_imem[ia[7:0]]);
        if (rw) begin
            mdl_rd(da, e, k);
            if (k) check({tag, ".dd"}, dd, e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1; ld_data = b; ld_last = last;
        tick();
        ld_valid = 0; ld_last = 0;
    endtask

    task automatic pulse_start();
        ld_start = 1;
        tick();
        ld_start = 0;
    endtask

    initial begin
        logic [15:0] cyc_exp;
        int nw;
        rst_n = 1; rw = 1; ia = 0; da = 0; dd_drv = 0;
        ld_valid = 0; ld_last = 0; ld_start = 0; ld_data = 0;
        mdl_reset();
        #2 rst_n = 0;
        repeat (2) @(posedge ck);
        #1;
        check("reset.cpu_rst", {15'd0, cpu_rst}, 16'd1);
        check("reset.ld_ready", {15'd0, ld_ready}, 16'd1);
        check("reset.gpo", gpo, 16'd0);
        #2 rst_n = 1;
        @(posedge ck); #1;

        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'h56, 0); send_byte(8'h78, 1);
        check("load.cpu_rst", {15'd0, cpu_rst}, 16'd0);
        ia = 16'd0; #1 check("load.imem0", id, 16'h1234);
        ia = 16'd1; #1 check("load.imem1", id, 16'h5678);
        ia = 16'h0101; #1 check("load.ia_oor", id, 16'h0000);
        rw = 1; da = 16'hFFFE;
        repeat (10) tick();
`ifdef CPU_MEM_CYCCNT_EN
        cyc_exp = 16'h000A;
`else
        cyc_exp = 16'h0000;
`endif
        check("cyc.read", dd, cyc_exp);

        tbl.push_back('{16'h0005, 16'hBEEF, 16'hBEEF});
        tbl.push_back('{16'h0105, 16'h1234, 16'h0000});
        tbl.push_back('{16'hFFFF, 16'h00A5, 16'h00A5});
        tbl.push_back('{16'h00FF, 16'h5A5A, 16'h5A5A});
        tbl.push_back('{16'h0000, 16'h0001, 16'h0001});
        tbl.push_back('{16'h8005, 16'hDEAD, 16'h0000});
`ifndef CPU_MEM_CYCCNT_EN
        tbl.push_back('{16'hFFFE, 16'h2222, 16'h0000});
`endif
        foreach (tbl[i]) begin
            rw = 0; da = tbl[i].da; dd_drv = tbl[i].wd;
            tick();
            rw = 1; #1;
            check($sformatf("tbl%0d.dd", i), dd, tbl[i].rd);
            check_all($sformatf("tbl%0d", i));
        end
        check("gpo.after_write", gpo, 16'h00A5);
        da = 16'h0005; #1 check("dmem5.kept", dd, 16'hBEEF);

        ld_start = 1; ld_valid = 1; ld_data = 8'h99; ld_last = 1;
        tick();
        ld_start = 0; ld_valid = 0; ld_last = 0;
        check("start.cpu_rst", {15'd0, cpu_rst}, 16'd1);
        check("start.ld_ready", {15'd0, ld_ready}, 16'd1);
        rw = 0; da = 16'hFFFF; dd_drv = 16'h1234; tick();
        da = 16'h0005; dd_drv = 16'h0000; tick();
        rw = 1;
        check("load.gpo_locked", gpo, 16'h00A5);
        send_byte(8'hAA, 1);
        check("hi_last.ignored", {15'd0, cpu_rst}, 16'd1);
        send_byte(8'hBB, 1);
        ia = 16'd0; #1 check("reload.imem0", id, 16'hAABB);
        check("reload.cpu_rst", {15'd0, cpu_rst}, 16'd0);
        da = 16'h0005; #1 check("reload.dmem5", dd, 16'hBEEF);

        pulse_start();
        send_byte(8'h77, 0);
        rst_n = 0; mdl_reset();
        #2;
        check("midrst.cpu_rst", {15'd0, cpu_rst}, 16'd1);
        check("midrst.gpo", gpo, 16'd0);
        rst_n = 1;
        send_byte(8'h01, 0); send_byte(8'h02, 1);
        ia = 16'd0; #1 check("midrst.imem0", id, 16'h0102);
        check_all("midrst");

        pulse_start();
        for (int k = 0; k < 257; k++) begin
            send_byte(8'hC0 + 8'(k >> 8), 0);
            send_byte(8'(k), k == 256);
        end
        ia = 16'd0;   #1 check("wrap.imem0", id, 16'hC100);
        ia = 16'd1;   #1 check("wrap.imem1", id, 16'hC001);
        ia = 16'd255; #1 check("wrap.imem255", id, 16'hC0FF);
        check_all("wrap");

        for (int l = 0; l < 3; l++) begin
            pulse_start();
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 1) == 1) tick();
                send_byte(8'($urandom), $urandom_range(0, 3) == 0);
                check_all("rload.hi");
                send_byte(8'($urandom), w == nw - 1);
                check_all("rload.lo");
            end
            for (int w = 0; w < nw; w++) begin
                ia = 16'(w); #1 check_all("rload.rd");
            end
        end

        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            ia = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0100) : 16'($urandom_range(0, 255));
            if (sel < 5) da = 16'($urandom_range(0, 15));
            else if (sel < 7) da = 16'hFFFF;
            else if (sel < 8) da = 16'hFFFE;
            else da = 16'($urandom);
            rw = ($urandom_range(0, 2) != 0);
            dd_drv = 16'($urandom);
            #1 check_all("rnd");
            tick();
        end
        rw = 1; #1 check_all("rnd.end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
